// File: rtl/ser_par_pkg.sv
// Shared types and defaults for the serial-to-parallel sequencing controller.
// PARITY_BIT is only reachable when SER_PAR_PARITY_CHK_EN is defined.
package ser_par_pkg;

  localparam int WORD_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT      = 3'd1,
    WRITE      = 3'd2,
    ABORT      = 3'd3,
    PARITY_BIT = 3'd4
  } state_t;

  // Bit counter width; never narrower than one bit so WORD_W==1 still elaborates.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_par_idle_timer.sv
// Idle-cycle counter for partial words: clears on activity, counts En-low
// cycles and flags expiry on the cycle that completes TIMEOUT idle cycles.
module ser_par_idle_timer #(
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (i_clr) begin
      r_to_cnt <= '0;
    end else if (i_inc) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign o_expire = i_inc & ~i_clr & (r_to_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ser_par_ctrl.sv
// Sequencing controller for the 32-bit serial-to-parallel converter.
// Optional even-parity check per word is enabled by defining SER_PAR_PARITY_CHK_EN.
module ser_par_ctrl
  import ser_par_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 4,
  parameter int WCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic              Data_in,
  input  logic              fifo_full,
  input  logic              clr_flags,
  output logic              Shft,
  output logic              write,
  output logic              clr,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err,
  output logic              parity_err,
  output logic [WCNT_W-1:0] word_cnt
);

  localparam int              BC_W     = clog2_min1(WORD_W);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WORD_W - 1);

  state_t            r_state;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WCNT_W-1:0] r_word_cnt;
  logic              r_overrun;
  logic              r_frame_err;
  logic              w_accept;
  logic              w_timed;
  logic              w_drop;
  logic              w_to_expire;

`ifdef SER_PAR_PARITY_CHK_EN
  localparam state_t LAST_NEXT = PARITY_BIT;
  logic r_par;
  logic r_par_abort;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  localparam state_t LAST_NEXT = WRITE;
  logic w_unused;
  assign w_unused   = Data_in;
  assign parity_err = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) || (r_state == SHIFT);
  assign w_timed  = (r_state == SHIFT) || (r_state == PARITY_BIT);
  assign w_drop   = En & ((r_state == WRITE) || (r_state == ABORT));

  // Shft must be quiet during reset even though the reset state is IDLE.
  assign Shft      = rst & En & w_accept;
  assign write     = (r_state == WRITE) & ~fifo_full;
  assign clr       = (r_state == ABORT);
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign word_cnt  = r_word_cnt;

  ser_par_idle_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (~w_timed | En),
    .i_inc    (w_timed & ~En),
    .o_expire (w_to_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SER_PAR_PARITY_CHK_EN
      r_par        <= 1'b0;
      r_par_abort  <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // Clears come first so a coincident set event below takes priority.
      if (clr_flags) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
`ifdef SER_PAR_PARITY_CHK_EN
        r_parity_err <= 1'b0;
`endif
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (En) begin
            r_bit_cnt <= BC_W'(1);
            r_state   <= (WORD_W == 1) ? LAST_NEXT : SHIFT;
`ifdef SER_PAR_PARITY_CHK_EN
            r_par       <= Data_in;
            r_par_abort <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (En) begin
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
`ifdef SER_PAR_PARITY_CHK_EN
            r_par <= r_par ^ Data_in;
`endif
            if (r_bit_cnt == LAST_IDX) begin
              r_state <= LAST_NEXT;
            end
          end else if (w_to_expire) begin
            r_state <= ABORT;
          end
        end
`ifdef SER_PAR_PARITY_CHK_EN
        PARITY_BIT: begin
          if (En) begin
            if (Data_in == r_par) begin
              r_state <= WRITE;
            end else begin
              r_parity_err <= 1'b1;
              r_par_abort  <= 1'b1;
              r_state      <= ABORT;
            end
          end else if (w_to_expire) begin
            r_state <= ABORT;
          end
        end
`endif
        WRITE: begin
          if (!fifo_full) begin
            r_word_cnt <= r_word_cnt + WCNT_W'(1);
            r_bit_cnt  <= '0;
            r_state    <= IDLE;
          end
        end
        ABORT: begin
          r_bit_cnt <= '0;
          r_state   <= IDLE;
`ifdef SER_PAR_PARITY_CHK_EN
          r_par_abort <= 1'b0;
          if (!r_par_abort) begin
            r_frame_err <= 1'b1;
          end
`else
          r_frame_err <= 1'b1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ser_par_ctrl.md
Name: ser_par_ctrl

Overview:
Sequencing controller for the 32-bit serial-to-parallel converter datapath.
- Qualifies incoming serial bits and issues shift strobes.
- Counts bits per word; issues the write strobe into the downstream FIFO when a word completes.
- Stalls on FIFO full and aborts stale partial words after an idle timeout.
- Keeps sticky error flags and a written-word count for status readback.

Parameters:
WORD_W, 32, data bits per word; bit counter width is derived as clog2(WORD_W)
TIMEOUT, 15, idle cycles (En low) tolerated mid-word before abort; range 1..2^TO_W-1
TO_W, 4, timeout counter width
WCNT_W, 16, written-word counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
En  in  1  serial bit valid from source, one bit per cycle while high
Data_in  in  1  serial data bit; used only for parity tracking
fifo_full  in  1  downstream FIFO full
clr_flags  in  1  synchronous clear of sticky flags
Shft  out  1  shift strobe to converter datapath (combinational)
write  out  1  one-cycle FIFO write strobe (combinational)
clr  out  1  one-cycle datapath flush strobe (registered state decode)
busy  out  1  state != IDLE
overrun  out  1  sticky: bit arrived while not accepting
frame_err  out  1  sticky: partial word aborted by timeout
parity_err  out  1  sticky parity mismatch; constant 0 without the optional feature
word_cnt  out  WCNT_W  words written, wraps modulo 2^WCNT_W

Behaviour:
- Reset (rst=0, async): state IDLE; bit_cnt, to_cnt and word_cnt = 0; all sticky flags = 0. Shft, write and clr = 0 while in reset.
- States: IDLE, SHIFT, WRITE, ABORT; binary encoding.
- IDLE:
  - Shft = En.
  - En=1: bit_cnt <= 1, next state SHIFT. If WORD_W==1, go straight to WRITE.
- SHIFT:
  - Shft = En.
  - En=1: bit_cnt increments and to_cnt clears. When bit_cnt == WORD_W-1 with En=1, the last bit is shifted this cycle and next state is WRITE.
  - En=0: to_cnt increments. When to_cnt reaches TIMEOUT, next state is ABORT.
- WRITE:
  - Shft = 0.
  - write = ~fifo_full. When write=1: word_cnt increments, bit_cnt clears, next state IDLE.
  - fifo_full=1: hold in WRITE indefinitely; the word is retained in the datapath.
  - En=1 in WRITE: the bit is dropped and overrun is set.
- ABORT (one cycle): clr=1, frame_err set, bit_cnt and to_cnt clear, next state IDLE. En=1 in ABORT is dropped and sets overrun.
- Latency: the last data bit's En cycle is followed by write asserted in the next cycle, provided fifo_full=0.
- Minimum word period is WORD_W+1 cycles. With En held high continuously, exactly one bit per word is lost, with overrun set.
- clr_flags=1 clears the sticky flags. If a set event coincides with clr_flags, the set wins.
- word_cnt wraps from all-ones to 0 with no flag.
- Reset mid-word or mid-stall: the word is discarded, no write is issued, and all state is cleared immediately.

Optional Feature:
Macro SER_PAR_PARITY_CHK_EN.
- Defined:
  - Each word is WORD_W data bits followed by one even-parity bit.
  - The controller accumulates XOR of Data_in over the data bits.
  - After WORD_W data bits the FSM enters PARITY_BIT, a state added only when the macro is defined, with Shft=0.
  - En=1 in PARITY_BIT samples the parity bit:
    - Match: go to WRITE.
    - Mismatch: set parity_err and go to ABORT (clr pulses, no write, frame_err not set).
  - Timeout applies in PARITY_BIT as in SHIFT.
- Undefined: no PARITY_BIT state, Data_in is ignored, parity_err is tied 0.

Decomposition:
- Package ser_par_pkg holds:
  - the state encoding typedef, including PARITY_BIT;
  - WORD_W and TIMEOUT defaults;
  - the clog2 helper for the bit counter width.
- Sub-module ser_par_idle_timer holds the to_cnt counter with clear/increment/expire.
- FSM, bit counter, word counter and flags stay in ser_par_ctrl.

Test Plan:
- Reset, then En high for 32 cycles with fifo_full=0 -> 32 Shft pulses, write=1 in cycle 33, word_cnt=1, busy=0 in cycle 34.
- En held high for 100 cycles -> write at cycles 33 and 66; overrun=1 after cycle 33; word_cnt=3 after cycle 99 write.
- 32 bits shifted, fifo_full=1 for 10 cycles then 0 -> write held low for 10 cycles, then a single pulse; word_cnt=1.
- 10 bits shifted, then En=0 for 15 cycles -> clr pulse, frame_err=1, word_cnt unchanged; clr_flags -> frame_err=0.
- rst=0 asserted mid-word at bit 20 -> all outputs 0 asynchronously; next 32-bit word is written correctly.
- SER_PAR_PARITY_CHK_EN: data 0x0000_0001 with parity bit 1 -> write; parity bit 0 -> parity_err=1, clr, no write.
